// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// FSM state encoding, the NOP encoding loaded on squash, and the counter width default.
package pipe_ctrl_pkg;

    localparam int CNT_W_DEFAULT = 16;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_STALL = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    typedef enum logic [1:0] {
        RUN   = ST_RUN,
        STALL = ST_STALL,
        FLUSH = ST_FLUSH
    } hz_state_e;

    // A squashed pipeline register carries an all-zero word: every op_* flag cleared.
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // Value loaded into the flush down-counter when a taken branch enters FLUSH.
    function automatic logic [2:0] flush_load(input int fc);
        return 3'(fc - 1);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
module sat_counter #(
    parameter int width = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clear,
    output logic [width-1:0] count
);

    logic [width-1:0] count_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {width{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: one bubble per load-use, FLUSH_CYCLES squash cycles per taken branch.
// Optional performance counters are built only when PIPE_HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = CNT_W_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             op_stall_data,
    input  logic             op_branch23,
    output logic             pc_we,
    output logic             pc_sel_branch,
    output logic             if_id_we,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [2:0] FLUSH_INIT = flush_load(FLUSH_CYCLES);

    logic [1:0] state_reg, state_next;
    logic [2:0] fcnt_reg, fcnt_next;
    logic       busy_reg;

    logic pc_we_c, pc_sel_c, if_id_we_c, if_id_flush_c, bubble_c;

    always_comb begin
        state_next    = ST_RUN;
        fcnt_next     = fcnt_reg;
        pc_we_c       = 1'b1;
        pc_sel_c      = 1'b0;
        if_id_we_c    = 1'b1;
        if_id_flush_c = 1'b0;
        bubble_c      = 1'b0;

        if (state_reg == ST_FLUSH) begin
            // Requests seen here come from wrong-path instructions and are dropped.
            if_id_flush_c = 1'b1;
            bubble_c      = 1'b1;
            fcnt_next     = fcnt_reg - 3'd1;
            if (fcnt_reg > 3'd1) begin
                state_next = ST_FLUSH;
            end
        end else if (op_branch23) begin
            pc_sel_c      = 1'b1;
            if_id_flush_c = 1'b1;
            bubble_c      = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_next = ST_FLUSH;
                fcnt_next  = FLUSH_INIT;
            end else begin
                fcnt_next  = 3'd0;
            end
        end else if (op_stall_data && (state_reg != ST_STALL)) begin
            // STALL masks the still-asserted request so only one bubble goes in.
            pc_we_c    = 1'b0;
            if_id_we_c = 1'b0;
            bubble_c   = 1'b1;
            state_next = ST_STALL;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_RUN;
            fcnt_reg  <= 3'd0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            fcnt_reg  <= fcnt_next;
            busy_reg  <= (state_next != ST_RUN);
        end
    end

    // While reset is low the pipeline is frozen and squashed.
    assign pc_we         = reset & pc_we_c;
    assign pc_sel_branch = reset & pc_sel_c;
    assign if_id_we      = reset & if_id_we_c;
    assign if_id_flush   = ~reset | if_id_flush_c;
    assign id_ex_bubble  = ~reset | bubble_c;
    assign busy          = busy_reg;

`ifdef PIPE_HAZARD_PERF_EN
    logic [1:0]       perf_evt;
    logic [CNT_W-1:0] perf_val [2];

    assign perf_evt[0] = (state_reg != ST_FLUSH) & (state_reg != ST_STALL)
                       & op_stall_data & ~op_branch23;
    assign perf_evt[1] = (state_reg != ST_FLUSH) & op_branch23;

    for (genvar gi = 0; gi < 2; gi++) begin : g_perf
        sat_counter #(
            .width (CNT_W)
        ) u_cnt (
            .clock (clock),
            .reset (reset),
            .inc   (perf_evt[gi]),
            .clear (1'b0),
            .count (perf_val[gi])
        );
    end

    assign stall_cnt = perf_val[0];
    assign flush_cnt = perf_val[1];
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: two instances (FLUSH_CYCLES=2/CNT_W=16 and
// FLUSH_CYCLES=4/CNT_W=2) share directed stimulus and are checked every cycle against a model.
module tb_pipe_hazard_ctrl;

    localparam int FC_A = 2;
    localparam int W_A  = 16;
    localparam int FC_B = 4;
    localparam int W_B  = 2;
`ifdef PIPE_HAZARD_PERF_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic op_stall_data = 1'b0;
    logic op_branch23 = 1'b0;

    always #5 clock = ~clock;

    logic           pc_we_a, pc_sel_a, if_id_we_a, if_id_flush_a, bubble_a, busy_a;
    logic [W_A-1:0] scnt_a, fcnt_a;
    logic           pc_we_b, pc_sel_b, if_id_we_b, if_id_flush_b, bubble_b, busy_b;
    logic [W_B-1:0] scnt_b, fcnt_b;

    pipe_hazard_ctrl #(.FLUSH_CYCLES(FC_A), .CNT_W(W_A)) dut_a (
        .clock(clock), .reset(reset), .op_stall_data(op_stall_data), .op_branch23(op_branch23),
        .pc_we(pc_we_a), .pc_sel_branch(pc_sel_a), .if_id_we(if_id_we_a),
        .if_id_flush(if_id_flush_a), .id_ex_bubble(bubble_a), .busy(busy_a),
        .stall_cnt(scnt_a), .flush_cnt(fcnt_a)
    );

    pipe_hazard_ctrl #(.FLUSH_CYCLES(FC_B), .CNT_W(W_B)) dut_b (
        .clock(clock), .reset(reset), .op_stall_data(op_stall_data), .op_branch23(op_branch23),
        .pc_we(pc_we_b), .pc_sel_branch(pc_sel_b), .if_id_we(if_id_we_b),
        .if_id_flush(if_id_flush_b), .id_ex_bubble(bubble_b), .busy(busy_b),
        .stall_cnt(scnt_b), .flush_cnt(fcnt_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_no   = 0;

    // Model: squash cycles still owed, whether the previous cycle inserted a stall bubble,
    // and plain event tallies clipped at the counter ceiling.
    int fc_of [2]  = '{FC_A, FC_B};
    int max_of [2] = '{(1 << W_A) - 1, (1 << W_B) - 1};
    int m_rem [2]  = '{0, 0};
    int m_scnt [2] = '{0, 0};
    int m_fcnt [2] = '{0, 0};
    bit m_after [2] = '{1'b0, 1'b0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc_no, act, exp);
        end
    endtask

    task automatic check_dut(input int i, input logic pw, input logic ps, input logic iw,
                             input logic fl, input logic bb, input logic bz,
                             input logic [31:0] sc, input logic [31:0] fc);
        bit e_pw, e_ps, e_iw, e_fl, e_bb, e_bz;
        int e_sc, e_fc;
        if (!reset) begin
            e_pw = 0; e_ps = 0; e_iw = 0; e_fl = 1; e_bb = 1; e_bz = 0; e_sc = 0; e_fc = 0;
        end else begin
            e_bz = (m_rem[i] > 0) || m_after[i];
            e_sc = PERF * m_scnt[i];
            e_fc = PERF * m_fcnt[i];
            if (m_rem[i] > 0) begin
                e_pw = 1; e_ps = 0; e_iw = 1; e_fl = 1; e_bb = 1;
            end else if (op_branch23) begin
                e_pw = 1; e_ps = 1; e_iw = 1; e_fl = 1; e_bb = 1;
            end else if (op_stall_data && !m_after[i]) begin
                e_pw = 0; e_ps = 0; e_iw = 0; e_fl = 0; e_bb = 1;
            end else begin
                e_pw = 1; e_ps = 0; e_iw = 1; e_fl = 0; e_bb = 0;
            end
        end
        chk($sformatf("pc_we[%0d]", i), {31'd0, pw}, {31'd0, e_pw});
        chk($sformatf("pc_sel_branch[%0d]", i), {31'd0, ps}, {31'd0, e_ps});
        chk($sformatf("if_id_we[%0d]", i), {31'd0, iw}, {31'd0, e_iw});
        chk($sformatf("if_id_flush[%0d]", i), {31'd0, fl}, {31'd0, e_fl});
        chk($sformatf("id_ex_bubble[%0d]", i), {31'd0, bb}, {31'd0, e_bb});
        chk($sformatf("busy[%0d]", i), {31'd0, bz}, {31'd0, e_bz});
        chk($sformatf("stall_cnt[%0d]", i), sc, e_sc);
        chk($sformatf("flush_cnt[%0d]", i), fc, e_fc);
    endtask

    always @(negedge clock) begin
        check_dut(0, pc_we_a, pc_sel_a, if_id_we_a, if_id_flush_a, bubble_a, busy_a,
                  32'(scnt_a), 32'(fcnt_a));
        check_dut(1, pc_we_b, pc_sel_b, if_id_we_b, if_id_flush_b, bubble_b, busy_b,
                  32'(scnt_b), 32'(fcnt_b));
    end

    always @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                m_rem[i] = 0; m_scnt[i] = 0; m_fcnt[i] = 0; m_after[i] = 0;
            end else if (m_rem[i] > 0) begin
                m_rem[i]--;
                m_after[i] = 0;
            end else if (op_branch23) begin
                m_rem[i] = fc_of[i] - 1;
                m_after[i] = 0;
                if (m_fcnt[i] < max_of[i]) m_fcnt[i]++;
            end else if (op_stall_data && !m_after[i]) begin
                m_after[i] = 1;
                if (m_scnt[i] < max_of[i]) m_scnt[i]++;
            end else begin
                m_after[i] = 0;
            end
        end
    end

    // One cycle of stimulus; returns just after the negedge so literal checks see this cycle.
    task automatic cyc(input bit st, input bit br, input bit rs);
        @(posedge clock);
        #1;
        op_stall_data = st;
        op_branch23   = br;
        reset         = rs;
        cyc_no++;
        @(negedge clock);
        #1;
        $display("cyc %0d: rst_n=%0b stall=%0b br=%0b | a: pc_we=%0b sel=%0b fl=%0b bub=%0b busy=%0b sc=%0d fc=%0d | b: busy=%0b sc=%0d fc=%0d",
                 cyc_no, rs, st, br, pc_we_a, pc_sel_a, if_id_flush_a, bubble_a, busy_a,
                 scnt_a, fcnt_a, busy_b, scnt_b, fcnt_b);
    endtask

    initial begin
        #1 reset = 1'b0;

        // Reset held three cycles
        for (int k = 0; k < 3; k++) cyc(0, 0, 0);
        chk("rst_pc_we", {31'd0, pc_we_a}, 0);
        chk("rst_if_id_flush", {31'd0, if_id_flush_a}, 1);
        chk("rst_bubble", {31'd0, bubble_a}, 1);
        chk("rst_busy", {31'd0, busy_a}, 0);

        cyc(0, 0, 1);
        chk("idle_pc_we", {31'd0, pc_we_a}, 1);
        chk("idle_if_id_we", {31'd0, if_id_we_a}, 1);
        chk("idle_busy", {31'd0, busy_a}, 0);
        chk("idle_stall_cnt", 32'(scnt_a), 0);

        // Load-use held two cycles: one bubble only
        cyc(1, 0, 1);
        chk("stall_pc_we", {31'd0, pc_we_a}, 0);
        chk("stall_bubble", {31'd0, bubble_a}, 1);
        cyc(1, 0, 1);
        chk("stall2_busy", {31'd0, busy_a}, 1);
        chk("stall2_pc_we", {31'd0, pc_we_a}, 1);
        cyc(0, 0, 1);
        chk("stall_done_busy", {31'd0, busy_a}, 0);
        chk("stall_cnt_one", 32'(scnt_a), PERF);

        // Taken branch, FLUSH_CYCLES=2
        cyc(0, 1, 1);
        chk("br0_sel", {31'd0, pc_sel_a}, 1);
        chk("br0_flush", {31'd0, if_id_flush_a}, 1);
        cyc(0, 0, 1);
        chk("br1_flush", {31'd0, if_id_flush_a}, 1);
        chk("br1_sel", {31'd0, pc_sel_a}, 0);
        chk("br1_busy", {31'd0, busy_a}, 1);
        cyc(0, 0, 1);
        chk("br2_busy", {31'd0, busy_a}, 0);
        chk("br2_flush", {31'd0, if_id_flush_a}, 0);
        chk("br_flush_cnt", 32'(fcnt_a), PERF);
        for (int k = 0; k < 3; k++) cyc(0, 0, 1);

        // Branch and stall together, then a wrong-path branch inside FLUSH
        cyc(0, 0, 0);
        cyc(0, 0, 1);
        cyc(1, 1, 1);
        chk("both_sel", {31'd0, pc_sel_a}, 1);
        chk("both_pc_we", {31'd0, pc_we_a}, 1);
        cyc(0, 1, 1);
        chk("wp_br_sel", {31'd0, pc_sel_a}, 0);
        chk("wp_br_flush", {31'd0, if_id_flush_a}, 1);
        cyc(0, 0, 1);
        chk("both_busy", {31'd0, busy_a}, 0);
        chk("both_flush_cnt", 32'(fcnt_a), PERF);
        chk("both_stall_cnt", 32'(scnt_a), 0);
        for (int k = 0; k < 4; k++) cyc(0, 0, 1);

        // Reset in the second FLUSH cycle of the FLUSH_CYCLES=4 instance
        cyc(0, 1, 1);
        cyc(0, 0, 1);
        chk("b_in_flush", {31'd0, busy_b}, 1);
        cyc(0, 0, 0);
        chk("b_rst_busy", {31'd0, busy_b}, 0);
        chk("b_rst_fcnt", 32'(fcnt_b), 0);
        chk("b_rst_pc_we", {31'd0, pc_we_b}, 0);
        cyc(0, 0, 1);
        chk("b_rel_flush", {31'd0, if_id_flush_b}, 0);
        chk("b_rel_busy", {31'd0, busy_b}, 0);
        chk("b_rel_pc_we", {31'd0, pc_we_b}, 1);
        cyc(0, 0, 1);
        chk("b_rel2_flush", {31'd0, if_id_flush_b}, 0);

        // Five separate stalls: CNT_W=2 saturates at 3
        for (int k = 0; k < 5; k++) begin
            cyc(1, 0, 1);
            cyc(0, 0, 1);
        end
        chk("b_stall_sat", 32'(scnt_b), 3 * PERF);
        chk("a_stall_five", 32'(scnt_a), 5 * PERF);

        // Taken branch arriving while in STALL
        cyc(1, 0, 1);
        cyc(1, 1, 1);
        chk("stbr_sel", {31'd0, pc_sel_a}, 1);
        chk("stbr_flush", {31'd0, if_id_flush_a}, 1);
        chk("stbr_busy", {31'd0, busy_a}, 1);
        for (int k = 0; k < 4; k++) cyc(0, 0, 1);
        chk("end_a_stall", 32'(scnt_a), 6 * PERF);
        chk("end_a_flush", 32'(fcnt_a), PERF);
        chk("end_busy", {31'd0, busy_b}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
